piso_serializer: RTL

//  Parallel-in serial-out front end for the serial shift-register stage.

---
 rtl/piso_serializer.sv | 91 +++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready word serializer with per-word bit order and a guard gap between frames
module piso_serializer #(
  parameter int WIDTH    = 8,
  parameter int GAP      = 2,
  parameter bit IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] par_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             msb_first,
  output logic             se_out,
  output logic             se_en,
  output logic             dir_out,
  output logic             frame_done
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [7:0] GAP_L = 8'(GAP);
  typedef enum logic [1:0] {IDLE, SHIFT, GUARD} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       gap_q, gap_d;
  logic             se_out_q, se_out_d, se_en_q, se_en_d, dir_q, dir_d, done_q, done_d;
  logic             accept;
  assign in_ready   = (state_q == IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign se_out     = se_out_q;
  assign se_en      = se_en_q;
  assign dir_out    = dir_q;
  assign frame_done = done_q;
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    se_out_d = se_out_q;
    se_en_d  = se_en_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        sr_d     = msb_first ? par_in << 1 : par_in >> 1;
        se_out_d = msb_first ? par_in[WIDTH-1] : par_in[0];
        dir_d    = msb_first;
        se_en_d  = 1'b1;
        cnt_d    = CW'(1);
        state_d  = SHIFT;
      end
      SHIFT: if (cnt_q < CW'(WIDTH)) begin
        se_out_d = dir_q ? sr_q[WIDTH-1] : sr_q[0];
        sr_d     = dir_q ? sr_q << 1 : sr_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        done_d   = (cnt_q == CW'(WIDTH - 1));
      end else begin
        se_en_d  = 1'b0;
        se_out_d = IDLE_BIT;
        cnt_d    = '0;
        gap_d    = GAP_L;
        state_d  = (GAP == 0) ? IDLE : GUARD;
      end
      GUARD: begin
        gap_d   = gap_q - 1'b1;
        state_d = (gap_q <= 8'd1) ? IDLE : GUARD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      se_out_q <= IDLE_BIT;
      se_en_q  <= 1'b0;
      dir_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      se_out_q <= se_out_d;
      se_en_q  <= se_en_d;
      dir_q    <= dir_d;
      done_q   <= done_d;
    end
  end
endmodule
